// File: rtl/alu_control_seq.sv
// RV64I/RV64M ALU control decoder plus a counter-based sequencer for the
// multi-cycle multiply/divide unit; holds the core in stall while an M op runs.
module alu_control_seq #(
  parameter int INSTR_W      = 64,
  parameter int OP_W         = 5,
  parameter int M_EXT        = 1,
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES   = 64,
  parameter int DIV_CYCLES_W = 32,
  parameter int FAST_DIV0    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  input  logic [1:0]         alu_op_sel,
  input  logic               rs2_zero,
  input  logic               flush,
  output logic [OP_W-1:0]    alu_op,
  output logic               op_word,
  output logic               illegal,
  output logic               md_start,
  output logic               md_busy,
  output logic               md_done,
  output logic               stall
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_DIV  = 5'b10100;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b10110;
  localparam logic [4:0] OP_REMU = 5'b10111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  logic [31:0] instr;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  op_d;
  logic        ill_d;
  logic        word_d;
  logic        md_op;
  logic        md_div;
  logic        start_go;
  logic [6:0]  lat_m1;
  state_t      state;
  logic [6:0]  cnt;
  logic        busy_r;
  logic        done_r;
  logic        unused_instr;

  assign instr  = instruction[31:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign word_d = alu_op_sel[1] & instr[3];

  generate
    if (INSTR_W > 32) begin : g_wide
      assign unused_instr = ^{instruction[INSTR_W-1:32], instr[11:0], instr[24:15]};
    end else begin : g_narrow
      assign unused_instr = ^{instr[11:0], instr[24:15]};
    end
  endgenerate

  function automatic logic [4:0] base_op(input logic [2:0] fn3);
    case (fn3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  function automatic logic word_ok(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA,
      OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU: word_ok = 1'b1;
      default:                                  word_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] latency_m1(input logic is_div, input logic is_word,
                                            input logic div0);
    int unsigned lat;
    if (is_div && FAST_DIV0 != 0 && div0) lat = 1;
    else if (is_div && is_word)           lat = DIV_CYCLES_W;
    else if (is_div)                      lat = DIV_CYCLES;
    else                                  lat = MUL_CYCLES;
    return 7'(lat - 1);
  endfunction

  // Decode: combinational from instruction and alu_op_sel
  always_comb begin
    op_d  = OP_ADD;
    ill_d = 1'b0;
    case (alu_op_sel)
      2'b00: op_d = OP_ADD;
      2'b01: op_d = OP_SUB;
      2'b10: begin
        if (f7 == 7'b0000000) begin
          op_d = base_op(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          op_d = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          op_d = OP_SRA;
        end else if (f7 == 7'b0000001 && M_EXT != 0) begin
          op_d = {2'b10, f3};
        end else begin
          ill_d = 1'b1;
        end
      end
      default: begin
        // Immediate shifts: shamt is 6 bits for RV64, 5 bits for the *W forms
        op_d = base_op(f3);
        if (f3 == 3'b001) begin
          ill_d = word_d ? (instr[31:25] != 7'd0) : (instr[31:26] != 6'd0);
        end else if (f3 == 3'b101) begin
          if (instr[30]) op_d = OP_SRA;
          ill_d = word_d ? ({instr[31], instr[29:25]} != 6'd0)
                         : ({instr[31], instr[29:26]} != 5'd0);
        end
      end
    endcase
    if (word_d && !word_ok(op_d)) ill_d = 1'b1;
    if (ill_d) op_d = OP_ADD;
  end

  assign md_op    = instr_valid & ~ill_d & op_d[4];
  assign md_div   = op_d[4] & op_d[2];
  assign lat_m1   = latency_m1(md_div, word_d, rs2_zero);
  assign start_go = (state == S_IDLE) & md_op & ~flush & ~reset;

  // Sequencer: IDLE -> BUSY (LAT cycles) -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 7'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_op && !flush) begin
            state  <= S_BUSY;
            cnt    <= lat_m1;
            busy_r <= 1'b1;
          end
        end
        S_BUSY: begin
          if (flush) begin
            state  <= S_IDLE;
            cnt    <= 7'd0;
            busy_r <= 1'b0;
          end else if (cnt == 7'd0) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            cnt <= cnt - 7'd1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= 7'd0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // A flush in BUSY/DONE releases the core in the same cycle and drops the result
  assign alu_op   = OP_W'(op_d);
  assign op_word  = word_d;
  assign illegal  = ill_d;
  assign md_start = start_go;
  assign md_busy  = busy_r;
  assign md_done  = done_r & ~flush;
  assign stall    = start_go | (busy_r & ~flush);

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed scenarios plus randomized
// decode and mul/div sequencing against a transaction-level reference model.
module tb_alu_control_seq;

  localparam int LAT_MUL = 4;
  localparam int LAT_DIV = 64;
  localparam int LAT_DIVW = 32;

  localparam logic [4:0] A_AND = 5'b00000, A_OR = 5'b00001, A_ADD = 5'b00010, A_XOR = 5'b00011;
  localparam logic [4:0] A_SLL = 5'b00100, A_SRL = 5'b00101, A_SUB = 5'b00110, A_SRA = 5'b00111;
  localparam logic [4:0] A_SLT = 5'b01000, A_SLTU = 5'b01001;
  localparam logic [4:0] A_MUL = 5'b10000, A_DIV = 5'b10100, A_DIVU = 5'b10101;
  localparam logic [4:0] A_REM = 5'b10110, A_REMU = 5'b10111;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] instruction;
  logic        instr_valid;
  logic [1:0]  alu_op_sel;
  logic        rs2_zero;
  logic        flush;
  logic [4:0]  alu_op, nm_alu_op;
  logic        op_word, nm_op_word, illegal, nm_illegal;
  logic        md_start, nm_md_start, md_busy, nm_md_busy;
  logic        md_done, nm_md_done, stall, nm_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_control_seq #(.INSTR_W(64), .OP_W(5), .M_EXT(1), .MUL_CYCLES(LAT_MUL),
                    .DIV_CYCLES(LAT_DIV), .DIV_CYCLES_W(LAT_DIVW), .FAST_DIV0(1)) u_dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .alu_op_sel(alu_op_sel), .rs2_zero(rs2_zero), .flush(flush), .alu_op(alu_op),
    .op_word(op_word), .illegal(illegal), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .stall(stall));

  alu_control_seq #(.INSTR_W(64), .OP_W(5), .M_EXT(0), .MUL_CYCLES(LAT_MUL),
                    .DIV_CYCLES(LAT_DIV), .DIV_CYCLES_W(LAT_DIVW), .FAST_DIV0(1)) u_nm (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .alu_op_sel(alu_op_sel), .rs2_zero(rs2_zero), .flush(flush), .alu_op(nm_alu_op),
    .op_word(nm_op_word), .illegal(nm_illegal), .md_start(nm_md_start), .md_busy(nm_md_busy),
    .md_done(nm_md_done), .stall(nm_stall));

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_base(input logic [2:0] f3);
    case (f3)
      3'd0: return A_ADD;  3'd1: return A_SLL;  3'd2: return A_SLT; 3'd3: return A_SLTU;
      3'd4: return A_XOR;  3'd5: return A_SRL;  3'd6: return A_OR;  default: return A_AND;
    endcase
  endfunction

  function automatic void ref_decode(input logic [31:0] ins, input logic [1:0] sel, input bit m_ext,
                                     output logic [4:0] op, output logic ill, output logic word);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [6:0] mask;
    f3 = ins[14:12];
    f7 = ins[31:25];
    word = sel[1] & ins[3];
    op = A_ADD;
    ill = 1'b0;
    if (sel == 2'b01) op = A_SUB;
    else if (sel == 2'b10) begin
      if (f7 == 7'h00) op = ref_base(f3);
      else if (f7 == 7'h20 && f3 == 3'd0) op = A_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) op = A_SRA;
      else if (f7 == 7'h01 && m_ext) op = {2'b10, f3};
      else ill = 1'b1;
    end else if (sel == 2'b11) begin
      op = ref_base(f3);
      if (f3 == 3'd1 || f3 == 3'd5) begin
        mask = word ? 7'h7F : 7'h7E;
        if (f3 == 3'd5) begin
          mask = mask & 7'h5F;
          if (ins[30]) op = A_SRA;
        end
        if ((f7 & mask) != 7'h00) ill = 1'b1;
      end
    end
    if (word && !(op inside {A_ADD, A_SUB, A_SLL, A_SRL, A_SRA, A_MUL, A_DIV, A_DIVU, A_REM, A_REMU}))
      ill = 1'b1;
    if (ill) op = A_ADD;
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic word, input logic rz);
    bit is_div;
    is_div = (op >= A_DIV) && (op <= A_REMU);
    if (is_div && rz) return 1;
    if (is_div && word) return LAT_DIVW;
    if (is_div) return LAT_DIV;
    return LAT_MUL;
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic word);
    logic [4:0] rs2, rs1, rd;
    rs2 = 5'($urandom);
    rs1 = 5'($urandom);
    rd  = 5'($urandom);
    return {f7, rs2, rs1, f3, rd, (word ? 7'h3B : 7'h33)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; instruction = 64'd0; instr_valid = 1'b0; alu_op_sel = 2'b00;
    rs2_zero = 1'b0; flush = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++; if (md_start !== 1'b0) begin bad++; $display("FAIL reset_md_start got=%b exp=0", md_start); end
    total++; if (md_busy  !== 1'b0) begin bad++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
    total++; if (md_done  !== 1'b0) begin bad++; $display("FAIL reset_md_done got=%b exp=0", md_done); end
    total++; if (stall    !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (alu_op   !== A_ADD) begin bad++; $display("FAIL reset_alu_op got=%b exp=%b", alu_op, A_ADD); end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_rtype_sweep();
    logic [4:0] exp_tbl [8];
    exp_tbl[0] = A_ADD; exp_tbl[1] = A_SLL; exp_tbl[2] = A_SLT; exp_tbl[3] = A_SLTU;
    exp_tbl[4] = A_XOR; exp_tbl[5] = A_SRL; exp_tbl[6] = A_OR;  exp_tbl[7] = A_AND;
    for (int i = 0; i < 8; i++) begin
      instruction = {32'($urandom), r_type(7'h00, 3'(i), 1'b0)};
      alu_op_sel = 2'b10; instr_valid = 1'b1;
      @(negedge clk);
      total++; if (alu_op !== exp_tbl[i]) begin bad++; $display("FAIL sweep_op f3=%0d got=%b exp=%b", i, alu_op, exp_tbl[i]); end
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL sweep_illegal f3=%0d got=%b exp=0", i, illegal); end
      total++; if (op_word !== 1'b0) begin bad++; $display("FAIL sweep_word f3=%0d got=%b exp=0", i, op_word); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL sweep_stall f3=%0d got=%b exp=0", i, stall); end
      next_cycle();
    end
  endtask

  task automatic test_word_ops();
    logic [31:0] ins [5];
    logic [1:0]  sel [5];
    logic [4:0]  e_op [5];
    logic        e_wd [5];
    logic        e_il [5];
    ins[0] = 32'h4050D09B; sel[0] = 2'b11; e_op[0] = A_SRA; e_wd[0] = 1'b1; e_il[0] = 1'b0;
    ins[1] = 32'h40B5053B; sel[1] = 2'b10; e_op[1] = A_SUB; e_wd[1] = 1'b1; e_il[1] = 1'b0;
    ins[2] = 32'h02B5153B; sel[2] = 2'b10; e_op[2] = A_ADD; e_wd[2] = 1'b1; e_il[2] = 1'b1;
    ins[3] = 32'hFFFFFFFF; sel[3] = 2'b00; e_op[3] = A_ADD; e_wd[3] = 1'b0; e_il[3] = 1'b0;
    ins[4] = 32'h02B5453B; sel[4] = 2'b01; e_op[4] = A_SUB; e_wd[4] = 1'b0; e_il[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instruction = {32'd0, ins[i]}; alu_op_sel = sel[i]; instr_valid = 1'b1;
      @(negedge clk);
      total++; if (alu_op !== e_op[i]) begin bad++; $display("FAIL word_op i=%0d got=%b exp=%b", i, alu_op, e_op[i]); end
      total++; if (op_word !== e_wd[i]) begin bad++; $display("FAIL word_flag i=%0d got=%b exp=%b", i, op_word, e_wd[i]); end
      total++; if (illegal !== e_il[i]) begin bad++; $display("FAIL word_illegal i=%0d got=%b exp=%b", i, illegal, e_il[i]); end
      total++; if ({md_start, stall} !== 2'b00) begin bad++; $display("FAIL word_nostart i=%0d got=%b exp=00", i, {md_start, stall}); end
      next_cycle();
    end
  endtask

  task automatic test_mul_back_to_back();
    instruction = {32'd0, 32'h02B50533}; alu_op_sel = 2'b10; instr_valid = 1'b1; rs2_zero = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) instr_valid = 1'b1;
      @(negedge clk);
      total++; if (md_start !== (k == 0 || k == 6)) begin bad++; $display("FAIL mul_start k=%0d got=%b", k, md_start); end
      total++; if (stall !== (k <= 4 || k == 6)) begin bad++; $display("FAIL mul_stall k=%0d got=%b", k, stall); end
      total++; if (md_busy !== (k >= 1 && k <= 4)) begin bad++; $display("FAIL mul_busy k=%0d got=%b", k, md_busy); end
      total++; if (md_done !== (k == 5)) begin bad++; $display("FAIL mul_done k=%0d got=%b", k, md_done); end
      next_cycle();
    end
    instr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++; if (md_done !== (k == 5)) begin bad++; $display("FAIL b2b_done k=%0d got=%b", k, md_done); end
      total++; if (stall !== (k <= 4)) begin bad++; $display("FAIL b2b_stall k=%0d got=%b", k, stall); end
      next_cycle();
    end
  endtask

  task automatic test_divw();
    int lat_exp, nstall;
    for (int rz = 0; rz < 2; rz++) begin
      lat_exp = (rz != 0) ? 1 : 32;
      nstall = 0;
      instruction = {32'd0, 32'h02B5453B}; alu_op_sel = 2'b10; instr_valid = 1'b1;
      rs2_zero = (rz != 0);
      for (int k = 0; k <= lat_exp + 1; k++) begin
        @(negedge clk);
        if (stall === 1'b1) nstall++;
        total++; if (md_done !== (k == lat_exp + 1)) begin bad++; $display("FAIL divw_done rz=%0d k=%0d got=%b", rz, k, md_done); end
        next_cycle();
      end
      total++; if (nstall !== lat_exp + 1) begin bad++; $display("FAIL divw_stall_cycles rz=%0d got=%0d exp=%0d", rz, nstall, lat_exp + 1); end
      instr_valid = 1'b0; rs2_zero = 1'b0;
      @(negedge clk);
      total++; if ({md_busy, md_done, stall} !== 3'b000) begin bad++; $display("FAIL divw_idle rz=%0d got=%b", rz, {md_busy, md_done, stall}); end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    bit seen_done;
    for (int v = 0; v < 2; v++) begin
      seen_done = 1'b0;
      instruction = {32'd0, 32'h02B54533}; alu_op_sel = 2'b10; instr_valid = 1'b1; rs2_zero = 1'b0;
      for (int k = 0; k <= 10; k++) begin
        if (k == 10 && v == 0) flush = 1'b1;
        if (k == 10 && v == 1) reset = 1'b1;
        @(negedge clk);
        seen_done |= md_done;
        if (k < 10) begin
          total++; if (stall !== 1'b1) begin bad++; $display("FAIL div_stall v=%0d k=%0d got=%b exp=1", v, k, stall); end
        end else if (v == 0) begin
          total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
        end
        next_cycle();
      end
      flush = 1'b0; reset = 1'b0; instr_valid = 1'b0;
      @(negedge clk);
      total++; if ({md_start, md_busy, md_done, stall} !== 4'b0000) begin bad++; $display("FAIL abort_idle v=%0d got=%b exp=0000", v, {md_start, md_busy, md_done, stall}); end
      for (int k = 0; k < 70; k++) begin
        seen_done |= md_done;
        next_cycle();
        @(negedge clk);
      end
      total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL abort_no_done v=%0d got=%b exp=0", v, seen_done); end
      next_cycle();
    end
    // flush while IDLE blocks the start
    instruction = {32'd0, 32'h02B50533}; instr_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    total++; if ({md_start, stall} !== 2'b00) begin bad++; $display("FAIL idle_flush got=%b exp=00", {md_start, stall}); end
    next_cycle();
    flush = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL idle_flush_busy got=%b exp=0", md_busy); end
    next_cycle();
  endtask

  task automatic test_no_mext();
    instruction = {32'd0, 32'h02B50533}; alu_op_sel = 2'b10; instr_valid = 1'b1;
    @(negedge clk);
    total++; if (nm_illegal !== 1'b1) begin bad++; $display("FAIL nm_illegal got=%b exp=1", nm_illegal); end
    total++; if (nm_alu_op !== A_ADD) begin bad++; $display("FAIL nm_alu_op got=%b exp=%b", nm_alu_op, A_ADD); end
    total++; if ({nm_md_start, nm_stall} !== 2'b00) begin bad++; $display("FAIL nm_nostart got=%b exp=00", {nm_md_start, nm_stall}); end
    next_cycle();
    instr_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if ({nm_md_busy, nm_md_done} !== 2'b00) begin bad++; $display("FAIL nm_idle k=%0d got=%b exp=00", k, {nm_md_busy, nm_md_done}); end
      next_cycle();
    end
  endtask

  task automatic test_random_decode();
    logic [31:0] ins;
    logic [4:0]  e_op, n_op;
    logic        e_il, e_wd, n_il, n_wd;
    int          pick;
    instr_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      ins = $urandom;
      pick = $urandom_range(0, 3);
      if (pick == 0) ins[31:25] = 7'h00;
      else if (pick == 1) ins[31:25] = 7'h20;
      else if (pick == 2) ins[31:25] = 7'h01;
      alu_op_sel = 2'($urandom);
      instruction = {32'($urandom), ins};
      ref_decode(ins, alu_op_sel, 1'b1, e_op, e_il, e_wd);
      ref_decode(ins, alu_op_sel, 1'b0, n_op, n_il, n_wd);
      @(negedge clk);
      total++; if ({alu_op, illegal, op_word} !== {e_op, e_il, e_wd}) begin bad++;
        $display("FAIL rdec n=%0d ins=%h sel=%b got=%b/%b/%b exp=%b/%b/%b", n, ins, alu_op_sel, alu_op, illegal, op_word, e_op, e_il, e_wd); end
      total++; if ({nm_alu_op, nm_illegal, nm_op_word} !== {n_op, n_il, n_wd}) begin bad++;
        $display("FAIL rdec_nm n=%0d ins=%h sel=%b got=%b/%b/%b exp=%b/%b/%b", n, ins, alu_op_sel, nm_alu_op, nm_illegal, nm_op_word, n_op, n_il, n_wd); end
      total++; if ({md_start, stall} !== 2'b00) begin bad++; $display("FAIL rdec_nostall n=%0d got=%b exp=00", n, {md_start, stall}); end
      next_cycle();
    end
  endtask

  task automatic test_random_md();
    logic [31:0] ins;
    logic [2:0]  f3;
    logic        word;
    logic [4:0]  e_op;
    logic        e_il, e_wd;
    int          lat, kf, last;
    logic        e_start, e_busy, e_done, e_stall;
    for (int n = 0; n < 40; n++) begin
      word = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if (word && (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3)) f3 = 3'd4 + 3'($urandom_range(0, 3));
      ins = r_type(7'h01, f3, word);
      instruction = {32'($urandom), ins}; alu_op_sel = 2'b10; instr_valid = 1'b1;
      rs2_zero = 1'($urandom); flush = 1'b0;
      ref_decode(ins, 2'b10, 1'b1, e_op, e_il, e_wd);
      lat = ref_lat(e_op, e_wd, rs2_zero);
      kf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat + 1)) : lat + 2;
      last = (kf <= lat + 1) ? kf : lat + 1;
      for (int k = 0; k <= last; k++) begin
        flush = (k == kf);
        if (k > 0) instr_valid = 1'($urandom);
        e_start = (k == 0);
        e_busy  = (k >= 1 && k <= lat);
        e_done  = (k == lat + 1) && (k != kf);
        e_stall = (k <= lat) && (k != kf);
        @(negedge clk);
        total++; if ({alu_op, illegal} !== {e_op, e_il}) begin bad++; $display("FAIL rmd_dec n=%0d k=%0d got=%b/%b exp=%b/%b", n, k, alu_op, illegal, e_op, e_il); end
        total++; if ({md_start, md_busy, md_done, stall} !== {e_start, e_busy, e_done, e_stall}) begin bad++;
          $display("FAIL rmd_seq n=%0d k=%0d lat=%0d kf=%0d got=%b exp=%b", n, k, lat, kf, {md_start, md_busy, md_done, stall}, {e_start, e_busy, e_done, e_stall}); end
        total++; if (nm_stall !== 1'b0) begin bad++; $display("FAIL rmd_nm_stall n=%0d k=%0d got=%b exp=0", n, k, nm_stall); end
        next_cycle();
      end
      flush = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        instr_valid = 1'b0;
        @(negedge clk);
        total++; if ({md_busy, md_done, stall} !== 3'b000) begin bad++; $display("FAIL rmd_idle n=%0d got=%b exp=000", n, {md_busy, md_done, stall}); end
        next_cycle();
      end
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype_sweep();
    test_word_ops();
    test_mul_back_to_back();
    test_divw();
    test_flush();
    test_no_mext();
    test_random_decode();
    test_random_md();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
